// File: rtl/register_read_port_pkg.sv
// Shared constants, buffer-state encoding and bank slicing helper for the
// register bank read side.
package register_read_port_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int SEL_W    = 3;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair_t;

    // Register idx lives at bits [DATA_W*idx +: DATA_W] of the flattened bank bus.
    function automatic logic [DATA_W-1:0] reg_slice(
        input logic [NUM_REGS*DATA_W-1:0] bus,
        input logic [SEL_W-1:0]           idx
    );
        return bus[DATA_W*idx +: DATA_W];
    endfunction

endpackage

// File: rtl/register_read_port_operand_select.sv
// Combinational selection of one operand: bank slice, or same-cycle write data
// when the single written register is the one being read.
module register_read_port_operand_select
    import register_read_port_pkg::*;
(
    input  logic [SEL_W-1:0]           src,
    input  logic [NUM_REGS*DATA_W-1:0] bank_q,
    input  logic [NUM_REGS-1:0]        wr_enable,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       fwd_allowed,
    output logic [DATA_W-1:0]          operand
);

    always_comb begin
        operand = reg_slice(bank_q, src);
        if (fwd_allowed && wr_enable[src]) begin
            operand = wr_data;
        end
    end

endmodule

// File: rtl/register_read_port.sv
// Operand fetch for the ALU: captures a source-register pair per request and
// hands it downstream through an output register backed by one skid entry.
module register_read_port
    import register_read_port_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SEL_W-1:0]           src_a,
    input  logic [SEL_W-1:0]           src_b,
    input  logic [NUM_REGS*DATA_W-1:0] bank_q,
    input  logic [NUM_REGS-1:0]        wr_enable,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       op_valid,
    input  logic                       op_ready,
    output logic [DATA_W-1:0]          op_a,
    output logic [DATA_W-1:0]          op_b,
    output logic                       wr_conflict
);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    pair_t      out_reg;
    pair_t      out_next;
    pair_t      skid_reg;
    pair_t      skid_next;
    pair_t      captured;
    logic       op_valid_reg;
    logic       op_valid_next;
    logic       ready_reg;
    logic       ready_next;
    logic       conflict_reg;

    logic accept;
    logic consume;
    logic multi_hot;
    logic one_hot;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi_hot = |(wr_enable & (wr_enable - NUM_REGS'(1)));
    assign one_hot   = (wr_enable != '0) && !multi_hot;

    register_read_port_operand_select u_sel_a (
        .src         (src_a),
        .bank_q      (bank_q),
        .wr_enable   (wr_enable),
        .wr_data     (wr_data),
        .fwd_allowed (one_hot),
        .operand     (captured.a)
    );

    register_read_port_operand_select u_sel_b (
        .src         (src_b),
        .bank_q      (bank_q),
        .wr_enable   (wr_enable),
        .wr_data     (wr_data),
        .fwd_allowed (one_hot),
        .operand     (captured.b)
    );

    // Ready is a flop; gating with rst_n only holds it low during reset.
    assign req_ready   = ready_reg & rst_n;
    assign accept      = req_valid & req_ready;
    assign consume     = op_valid_reg & op_ready;

    assign op_valid    = op_valid_reg;
    assign op_a        = out_reg.a;
    assign op_b        = out_reg.b;
    assign wr_conflict = conflict_reg;

    always_comb begin
        state_next    = state_reg;
        out_next      = out_reg;
        skid_next     = skid_reg;
        op_valid_next = op_valid_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    out_next      = captured;
                    op_valid_next = 1'b1;
                    state_next    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    out_next = captured;
                end else if (accept) begin
                    skid_next  = captured;
                    state_next = ST_TWO;
                end else if (consume) begin
                    op_valid_next = 1'b0;
                    state_next    = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    out_next   = skid_reg;
                    state_next = ST_ONE;
                end
            end
            default: begin
                state_next    = ST_EMPTY;
                op_valid_next = 1'b0;
            end
        endcase
        ready_next = (state_next != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            out_reg      <= '0;
            skid_reg     <= '0;
            op_valid_reg <= 1'b0;
            ready_reg    <= 1'b1;
            conflict_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            out_reg      <= out_next;
            skid_reg     <= skid_next;
            op_valid_reg <= op_valid_next;
            ready_reg    <= ready_next;
            conflict_reg <= accept & multi_hot;
        end
    end

endmodule
